// File: rtl/tcb_infer_sched.sv
// Round-robin scheduler sharing one TCB classifier core between NUM_REQ image sources.
// Optional watchdog (tag FIFO stall detection) enabled with `define TIMEOUT_EN.
module tcb_infer_sched #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned IMG_W        = 968,
    parameter int unsigned NUM_W        = 8,
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned TIMEOUT      = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*IMG_W-1:0]   req_img,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       core_valid,
    output logic [IMG_W-1:0]           core_img,
    input  logic                       core_ready,
    input  logic                       core_res_valid,
    input  logic [NUM_W-1:0]           core_res_number,
    output logic                       res_valid,
    output logic [$clog2(NUM_REQ)-1:0] res_id,
    output logic [NUM_W-1:0]           res_number,
    input  logic                       res_ready,
    output logic                       busy,
    output logic                       err
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned PTR_W = $clog2(MAX_INFLIGHT);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]       credit_q, credit_d;
    logic [IMG_W-1:0]       core_img_q, core_img_d;
    logic                   core_valid_q, core_valid_d;
    logic [NUM_REQ-1:0]     req_ready_q, req_ready_d;

    logic [ID_W-1:0]        tag_mem_q [MAX_INFLIGHT];
    logic [ID_W-1:0]        tag_mem_d [MAX_INFLIGHT];
    logic [PTR_W-1:0]       tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [CNT_W-1:0]       tag_cnt_q, tag_cnt_d;

    logic [ID_W-1:0]        rid_mem_q [MAX_INFLIGHT];
    logic [ID_W-1:0]        rid_mem_d [MAX_INFLIGHT];
    logic [NUM_W-1:0]       rnum_mem_q [MAX_INFLIGHT];
    logic [NUM_W-1:0]       rnum_mem_d [MAX_INFLIGHT];
    logic [PTR_W-1:0]       res_wr_q, res_wr_d, res_rd_q, res_rd_d;
    logic [CNT_W-1:0]       res_cnt_q, res_cnt_d;

    logic                   res_valid_q, res_valid_d;
    logic [ID_W-1:0]        res_id_q, res_id_d;
    logic [NUM_W-1:0]       res_number_q, res_number_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;

    logic [IMG_W-1:0]       img_arr [NUM_REQ];
    logic [ID_W-1:0]        gnt_idx;
    logic                   gnt_found;
    int unsigned            cand;
    logic                   grant, hs, tag_pop, res_push, res_pop;
    logic [ID_W-1:0]        tag_head;
    logic [CNT_W-1:0]       res_keep;
    logic                   wd_fire;

    // Unpack the flat image bus into one entry per requester.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_img
        assign img_arr[gi] = req_img[gi*IMG_W +: IMG_W];
    end

`ifdef TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            wd_run;

    // Watchdog runs while tags are outstanding and the core stays silent.
    always_comb begin
        wd_run  = (tag_cnt_q != '0) && !core_res_valid;
        wd_fire = wd_run && (wd_q == WD_W'(TIMEOUT - 1));
        wd_d    = (wd_run && !wd_fire) ? wd_q + WD_W'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) wd_q <= '0;
        else      wd_q <= wd_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
    assign wd_fire        = 1'b0;
`endif

    // Round-robin search starting just above the last winner.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(ptr_q) + k) % NUM_REQ;
            if (!gnt_found && req_valid[ID_W'(cand)]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(cand);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        credit_d     = credit_q;
        core_img_d   = core_img_q;
        req_ready_d  = '0;
        tag_mem_d    = tag_mem_q;
        tag_wr_d     = tag_wr_q;
        tag_rd_d     = tag_rd_q;
        tag_cnt_d    = tag_cnt_q;
        rid_mem_d    = rid_mem_q;
        rnum_mem_d   = rnum_mem_q;
        res_wr_d     = res_wr_q;
        res_rd_d     = res_rd_q;
        res_cnt_d    = res_cnt_q;
        res_id_d     = res_id_q;
        res_number_d = res_number_q;

        grant    = (state_q == IDLE) && gnt_found &&
                   (credit_q < CNT_W'(MAX_INFLIGHT)) && !wd_fire;
        hs       = (state_q == ISSUE) && core_ready && !wd_fire;
        tag_pop  = core_res_valid && (tag_cnt_q != '0);
        res_push = tag_pop;
        res_pop  = res_valid_q && res_ready;
        tag_head = tag_mem_q[tag_rd_q];

        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d     = ISSUE;
                    req_ready_d = NUM_REQ'(1) << gnt_idx;
                    core_img_d  = img_arr[gnt_idx];
                    ptr_d       = gnt_idx;
                end
            end
            ISSUE: begin
                if (hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (wd_fire) state_d = IDLE;

        // Tag FIFO: pushed on core handshake, popped by each core result.
        if (hs) begin
            tag_mem_d[tag_wr_q] = ptr_q;
            tag_wr_d            = tag_wr_q + PTR_W'(1);
        end
        if (tag_pop) tag_rd_d = tag_rd_q + PTR_W'(1);
        tag_cnt_d = tag_cnt_q + CNT_W'(hs) - CNT_W'(tag_pop);

        credit_d = credit_q + CNT_W'(grant) - CNT_W'(res_pop);
        if (wd_fire) begin
            // Flushed tags and any abandoned in-ISSUE image give their credit back.
            tag_rd_d  = tag_wr_q;
            tag_cnt_d = '0;
            credit_d  = credit_q - tag_cnt_q - CNT_W'(state_q == ISSUE) - CNT_W'(res_pop);
        end

        if (res_push) begin
            rid_mem_d[res_wr_q]  = tag_head;
            rnum_mem_d[res_wr_q] = core_res_number;
            res_wr_d             = res_wr_q + PTR_W'(1);
        end
        if (res_pop) res_rd_d = res_rd_q + PTR_W'(1);
        res_cnt_d = res_cnt_q + CNT_W'(res_push) - CNT_W'(res_pop);

        // Registered show-ahead: next head is an existing entry or the word being pushed.
        res_keep    = res_cnt_q - CNT_W'(res_pop);
        res_valid_d = (res_cnt_d != '0);
        if (res_keep != '0) begin
            res_id_d     = rid_mem_q[res_rd_d];
            res_number_d = rnum_mem_q[res_rd_d];
        end else if (res_push) begin
            res_id_d     = tag_head;
            res_number_d = core_res_number;
        end

        core_valid_d = (state_d == ISSUE);
        busy_d       = (credit_d != '0) || (state_d != IDLE);
        err_d        = err_q || (core_res_valid && (tag_cnt_q == '0)) || wd_fire;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            ptr_q        <= ID_W'(NUM_REQ - 1);
            credit_q     <= '0;
            core_img_q   <= '0;
            core_valid_q <= 1'b0;
            req_ready_q  <= '0;
            tag_mem_q    <= '{default: '0};
            tag_wr_q     <= '0;
            tag_rd_q     <= '0;
            tag_cnt_q    <= '0;
            rid_mem_q    <= '{default: '0};
            rnum_mem_q   <= '{default: '0};
            res_wr_q     <= '0;
            res_rd_q     <= '0;
            res_cnt_q    <= '0;
            res_valid_q  <= 1'b0;
            res_id_q     <= '0;
            res_number_q <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            credit_q     <= credit_d;
            core_img_q   <= core_img_d;
            core_valid_q <= core_valid_d;
            req_ready_q  <= req_ready_d;
            tag_mem_q    <= tag_mem_d;
            tag_wr_q     <= tag_wr_d;
            tag_rd_q     <= tag_rd_d;
            tag_cnt_q    <= tag_cnt_d;
            rid_mem_q    <= rid_mem_d;
            rnum_mem_q   <= rnum_mem_d;
            res_wr_q     <= res_wr_d;
            res_rd_q     <= res_rd_d;
            res_cnt_q    <= res_cnt_d;
            res_valid_q  <= res_valid_d;
            res_id_q     <= res_id_d;
            res_number_q <= res_number_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign core_valid = core_valid_q;
    assign core_img   = core_img_q;
    assign res_valid  = res_valid_q;
    assign res_id     = res_id_q;
    assign res_number = res_number_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_tcb_infer_sched.sv
// Directed bench for tcb_infer_sched: reset, round-robin order, stall, credit limit, error path.
module tb_tcb_infer_sched;

    localparam int unsigned NR = 4;
    localparam int unsigned IW = 968;
    localparam int unsigned NW = 8;
    localparam int unsigned MI = 4;
    localparam int unsigned TO = 16;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*IW-1:0]  req_img;
    logic [NR-1:0]     req_ready;
    logic              core_valid;
    logic [IW-1:0]     core_img;
    logic              core_ready;
    logic              core_res_valid;
    logic [NW-1:0]     core_res_number;
    logic              res_valid;
    logic [1:0]        res_id;
    logic [NW-1:0]     res_number;
    logic              res_ready;
    logic              busy;
    logic              err;

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    tcb_infer_sched #(
        .NUM_REQ(NR), .IMG_W(IW), .NUM_W(NW), .MAX_INFLIGHT(MI), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_img(req_img), .req_ready(req_ready),
        .core_valid(core_valid), .core_img(core_img), .core_ready(core_ready),
        .core_res_valid(core_res_valid), .core_res_number(core_res_number),
        .res_valid(res_valid), .res_id(res_id), .res_number(res_number),
        .res_ready(res_ready), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk_img(input int unsigned s);
        logic [IW-1:0] v;
        for (int k = 0; k < 121; k++) v[k*8 +: 8] = 8'(s * 31 + k);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid      = '0;
        core_res_valid = 1'b0;
        core_ready     = 1'b1;
        res_ready      = 1'b1;
        rst            = 1'b0;
        step();
        rst            = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst             = 1'b0;
        req_valid       = '0;
        core_ready      = 1'b1;
        core_res_valid  = 1'b0;
        core_res_number = '0;
        res_ready       = 1'b1;
        for (int i = 0; i < NR; i++) req_img[i*IW +: IW] = mk_img(i + 1);
        step();
        step();

        chk("rst_req_ready", req_ready, 0);
        chk("rst_core_valid", core_valid, 0);
        chk("rst_core_img", core_img == '0, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        rst = 1'b1;

        // Single requester, result number 7
        req_valid = 4'b0001;
        step();
        chk("t1_req_ready", req_ready, 4'b0001);
        chk("t1_core_valid", core_valid, 1);
        chk("t1_core_img", core_img == mk_img(1), 1);
        chk("t1_busy", busy, 1);
        req_valid = '0;
        step();
        chk("t1_core_valid_drop", core_valid, 0);
        chk("t1_req_ready_drop", req_ready, 0);
        core_res_valid  = 1'b1;
        core_res_number = 8'd7;
        step();
        core_res_valid = 1'b0;
        chk("t1_res_valid", res_valid, 1);
        chk("t1_res_id", res_id, 0);
        chk("t1_res_number", res_number, 7);
        step();
        chk("t1_res_popped", res_valid, 0);
        chk("t1_idle", busy, 0);

        // All requesters valid: grants rotate 0,1,2,3,0,...
        do_reset();
        req_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_gnt", req_ready, 64'(4'b0001 << (i % 4)));
            chk("rr_img", core_img == mk_img(i % 4 + 1), 1);
            if (i > 0) begin
                chk("rr_res_valid", res_valid, 1);
                chk("rr_res_id", res_id, 64'((i - 1) % 4));
                chk("rr_res_num", res_number, 64'(40 + i - 1));
            end
            core_res_valid = 1'b0;
            step();
            chk("rr_cv_low", core_valid, 0);
            core_res_valid  = 1'b1;
            core_res_number = 8'(40 + i);
            if (i == 7) req_valid = '0;
        end
        step();
        core_res_valid = 1'b0;
        chk("rr_last_id", res_id, 3);
        chk("rr_last_num", res_number, 47);
        step();
        chk("rr_drained", res_valid, 0);
        chk("rr_not_busy", busy, 0);

        // core_ready held low: image held, no further grants
        do_reset();
        req_valid  = 4'b0011;
        core_ready = 1'b0;
        step();
        chk("st_gnt0", req_ready, 4'b0001);
        req_valid = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("st_cv", core_valid, 1);
            chk("st_img", core_img == mk_img(1), 1);
            chk("st_no_gnt", req_ready, 0);
        end
        core_ready = 1'b1;
        step();
        chk("st_cv_drop", core_valid, 0);
        step();
        chk("st_gnt1", req_ready, 4'b0010);
        chk("st_img1", core_img == mk_img(2), 1);
        req_valid = '0;
        step();
        core_res_valid  = 1'b1;
        core_res_number = 8'd21;
        step();
        chk("st_res0_id", res_id, 0);
        chk("st_res0_num", res_number, 21);
        core_res_number = 8'd22;
        step();
        core_res_valid = 1'b0;
        chk("st_res1_id", res_id, 1);
        chk("st_res1_num", res_number, 22);
        step();
        chk("st_res_empty", res_valid, 0);

        // Credit exhaustion with res_ready low
        do_reset();
        res_ready = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("cr_gnt", req_ready, 64'(4'b0001 << i));
            step();
        end
        core_res_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            core_res_number = 8'(50 + i);
            step();
            chk("cr_no_gnt", req_ready, 0);
            chk("cr_head_valid", res_valid, 1);
            chk("cr_head_id", res_id, 0);
            chk("cr_head_num", res_number, 50);
        end
        core_res_valid = 1'b0;
        step();
        chk("cr_still_no_gnt", req_ready, 0);
        chk("cr_busy", busy, 1);
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("cr_pop_id", res_id, 64'(i + 1));
            chk("cr_pop_num", res_number, 64'(51 + i));
            if (i == 0) chk("cr_gnt_wait", req_ready, 0);
            if (i == 1) begin
                chk("cr_gnt_resume", req_ready, 4'b0001);
                req_valid = '0;
            end
        end
        step();
        chk("cr_empty", res_valid, 0);

        // Unexpected result sets sticky err; reset clears everything
        do_reset();
        core_res_valid = 1'b1;
        step();
        core_res_valid = 1'b0;
        chk("er_err", err, 1);
        chk("er_no_res", res_valid, 0);
        core_ready = 1'b0;
        req_valid  = 4'b0100;
        step();
        chk("er_gnt2", req_ready, 4'b0100);
        chk("er_sticky", err, 1);
        req_valid = '0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("er_rst_err", err, 0);
        chk("er_rst_req_ready", req_ready, 0);
        chk("er_rst_cv", core_valid, 0);
        chk("er_rst_img", core_img == '0, 1);
        chk("er_rst_res_valid", res_valid, 0);
        chk("er_rst_res_id", res_id, 0);
        chk("er_rst_res_num", res_number, 0);
        chk("er_rst_busy", busy, 0);

`ifdef TIMEOUT_EN
        // Watchdog flushes stuck tags and reopens issue
        do_reset();
        req_valid = 4'b0011;
        step();
        step();
        step();
        req_valid = '0;
        step();
        begin
            int unsigned waited = 0;
            while (!err && waited < 40) begin
                step();
                waited++;
            end
        end
        chk("wd_err", err, 1);
        chk("wd_busy", busy, 0);
        chk("wd_cv", core_valid, 0);
        req_valid = 4'b0100;
        step();
        chk("wd_regrant", req_ready, 4'b0100);
        req_valid = '0;
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
